csai_sequencer: RTL and testbench
=================================

// Module: csai_sequencer
// PURPOSE
//  Parametrised control-store address sequencer for the microprogrammed datapath; successor of the
//  plain +1 address incrementer. Registers the next control-store address each cycle. Supports
//  hold, increment, unconditional jump, conditional jump, and subroutine call/return via a LIFO stack.
//  Sits between microinstruction decode (op/branch fields) and the control-store ROM address input.
// PARAMETERS
//  AW          11  control-store address width (bits)
//  DEPTH        4  return-stack entries (>=1)
//  RESET_ADDR   0  address loaded on reset (AW bits)
//  DW  $clog2(DEPTH+1)  derived (localparam), width of depth counter
// PORTS
//  CSAI_SEQ_CLOCK_50               in   1   system clock, all state on rising edge
//  CSAI_SEQ_RESET_InHigh           in   1   synchronous, active-high reset
//  CSAI_SEQ_ACK                    in   1   advance enable; op executes only when 1
//  CSAI_SEQ_OP_InBus               in   3   sequencing op (encoding below)
//  CSAI_SEQ_COND                   in   1   branch condition for JCOND
//  CSAI_SEQ_BranchAddress_InBus    in   AW  target address for JMP/JCOND/CALL
//  CSAI_SEQ_ERRCLR                 in   1   leave HALT, clear error flags
//  CSAI_SEQ_CSAI_OutBus            out  AW  current control-store address (registered)
//  CSAI_SEQ_DEPTH_OutBus           out  DW  valid return-stack entries, 0..DEPTH
//  CSAI_SEQ_HALT                   out  1   1 while in HALT state
//  CSAI_SEQ_ERR_OutBus             out  2   sticky {overflow, underflow}
// BEHAVIOUR
//  - Reset (sync, highest priority): addr=RESET_ADDR, depth=0, err=2'b00, state=RUN, HALT=0.
//  - FSM: RUN, HALT. All outputs registered; an op sampled at edge N is visible after edge N.
//  - RUN, ACK=0: addr, depth and stack hold; op ignored.
//  - RUN, ACK=1, op decode (inc = addr+1 modulo 2^AW; AW'h7FF+1 -> 0 for AW=11):
//    000 HOLD   addr unchanged
//    001 INC    addr <= inc
//    010 JMP    addr <= BranchAddress
//    011 JCOND  COND=1: addr <= BranchAddress; COND=0: addr <= inc
//    100 CALL   depth<DEPTH: push inc, addr <= BranchAddress, depth+1
//    101 RET    depth>0: addr <= top of stack, pop, depth-1
//    110/111    reserved, executed as INC
//  - CALL with depth==DEPTH: no push, addr unchanged, err[1]<=1, state<=HALT.
//  - RET with depth==0: addr unchanged, err[0]<=1, state<=HALT.
//  - HALT: addr, depth and stack frozen; ACK and op ignored. ERRCLR=1: err<=0, state<=RUN
//    the following cycle; addr and depth are kept. ERRCLR in RUN: no effect.
//  - Stack is a register array plus a depth pointer. Entries above depth are don't-care.
//    There is no simultaneous push and pop; one op per cycle.
//  - Reset asserted mid-sequence discards the whole stack (depth=0) on that edge.
// CONFIGURATION
//  CSAI_SEQ_STACK_EN defined: CALL/RET and the stack are implemented as above.
//  CSAI_SEQ_STACK_EN undefined: no stack storage; CALL executes as JMP, RET as INC;
//    DEPTH_OutBus tied 0; overflow/underflow never raised (ERR_OutBus=0, HALT=0).
//    Ports and parameters are unchanged in both builds.
// TESTING
//  1 reset=1 with ACK=1, op=INC -> addr=RESET_ADDR, depth=0, err=00, HALT=0 each cycle.
//  2 addr=0x7FE, ACK=1, op=INC x2 -> 0x7FF then 0x000 (wrap); ACK=0 x3 -> stays 0x000.
//  3 addr=0x010, JCOND target 0x100, COND=0 -> 0x011; COND=1 -> 0x100; JMP 0x2AA -> 0x2AA.
//  4 addr=0x020, CALL 0x300 -> addr 0x300, depth 1; CALL 0x400 -> 0x400, depth 2;
//    RET -> 0x301, depth 1; RET -> 0x021, depth 0.
//  5 DEPTH=4: 4 CALLs then 5th CALL -> addr unchanged, ERR=10, HALT=1; INC ignored;
//    ERRCLR -> ERR=00, HALT=0, depth 4. RET at depth 0 -> ERR=01, HALT=1.
//  6 build without CSAI_SEQ_STACK_EN: CALL 0x123 -> addr 0x123, depth 0; RET -> 0x124, ERR=00.

Source files
------------

// File: rtl/csai_sequencer.sv
// Control-store address sequencer: hold/inc/jump/branch plus call/return through a LIFO stack.
// Define CSAI_SEQ_STACK_EN to build the return stack; otherwise CALL acts as JMP and RET as INC.
module csai_sequencer #(
  parameter int            AW         = 11,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                         CSAI_SEQ_CLOCK_50,
  input  logic                         CSAI_SEQ_RESET_InHigh,
  input  logic                         CSAI_SEQ_ACK,
  input  logic [2:0]                   CSAI_SEQ_OP_InBus,
  input  logic                         CSAI_SEQ_COND,
  input  logic [AW-1:0]                CSAI_SEQ_BranchAddress_InBus,
  input  logic                         CSAI_SEQ_ERRCLR,
  output logic [AW-1:0]                CSAI_SEQ_CSAI_OutBus,
  output logic [$clog2(DEPTH+1)-1:0]   CSAI_SEQ_DEPTH_OutBus,
  output logic                         CSAI_SEQ_HALT,
  output logic [1:0]                   CSAI_SEQ_ERR_OutBus
);

  localparam int DW = $clog2(DEPTH+1);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_JMP   = 3'b010;
  localparam logic [2:0] OP_JCOND = 3'b011;
  localparam logic [2:0] OP_CALL  = 3'b100;
  localparam logic [2:0] OP_RET   = 3'b101;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [1:0]      err_reg, err_next;
  logic [AW-1:0]   addr_inc;

  assign addr_inc = addr_reg + AW'(1);

`ifdef CSAI_SEQ_STACK_EN
  logic [DW-1:0]   depth_reg, depth_next;
  logic            push;
  logic [AW-1:0]   top_addr;
  logic [AW-1:0]   stack_mem [DEPTH];

  // Top of stack is the entry just below the depth pointer.
  always_comb begin
    top_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_reg == DW'(i + 1)) top_addr = stack_mem[i];
    end
  end

  always_ff @(posedge CSAI_SEQ_CLOCK_50) begin
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth_reg == DW'(i)) stack_mem[i] <= addr_inc;
      end
    end
  end

  assign CSAI_SEQ_DEPTH_OutBus = depth_reg;
`else
  assign CSAI_SEQ_DEPTH_OutBus = '0;
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    err_next   = err_reg;
`ifdef CSAI_SEQ_STACK_EN
    depth_next = depth_reg;
    push       = 1'b0;
`endif
    case (state_reg)
      S_RUN: begin
        if (CSAI_SEQ_ACK) begin
          case (CSAI_SEQ_OP_InBus)
            OP_HOLD:  addr_next = addr_reg;
            OP_JMP:   addr_next = CSAI_SEQ_BranchAddress_InBus;
            OP_JCOND: addr_next = CSAI_SEQ_COND ? CSAI_SEQ_BranchAddress_InBus : addr_inc;
`ifdef CSAI_SEQ_STACK_EN
            OP_CALL: begin
              if (depth_reg < DW'(DEPTH)) begin
                push       = 1'b1;
                addr_next  = CSAI_SEQ_BranchAddress_InBus;
                depth_next = depth_reg + DW'(1);
              end else begin
                err_next[1] = 1'b1;
                state_next  = S_HALT;
              end
            end
            OP_RET: begin
              if (depth_reg != '0) begin
                addr_next  = top_addr;
                depth_next = depth_reg - DW'(1);
              end else begin
                err_next[0] = 1'b1;
                state_next  = S_HALT;
              end
            end
`else
            OP_CALL:  addr_next = CSAI_SEQ_BranchAddress_InBus;
            OP_RET:   addr_next = addr_inc;
`endif
            default:  addr_next = addr_inc;
          endcase
        end
      end
      S_HALT: begin
        // Frozen until software acknowledges the stack fault.
        if (CSAI_SEQ_ERRCLR) begin
          err_next   = 2'b00;
          state_next = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CSAI_SEQ_CLOCK_50) begin
    if (CSAI_SEQ_RESET_InHigh) begin
      state_reg <= S_RUN;
      addr_reg  <= RESET_ADDR;
      err_reg   <= 2'b00;
`ifdef CSAI_SEQ_STACK_EN
      depth_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
`ifdef CSAI_SEQ_STACK_EN
      depth_reg <= depth_next;
`endif
    end
  end

  assign CSAI_SEQ_CSAI_OutBus = addr_reg;
  assign CSAI_SEQ_HALT        = (state_reg == S_HALT);
  assign CSAI_SEQ_ERR_OutBus  = err_reg;

endmodule

// File: tb/tb_csai_sequencer.sv
// Directed bench for csai_sequencer: queue-based reference model checked every cycle,
// plus hand-computed literal checkpoints. Follows CSAI_SEQ_STACK_EN like the design.
module tb_csai_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        cond = 1'b0;
  logic [10:0] br = '0;
  logic        errclr = 1'b0;
  logic [10:0] csai;
  logic [2:0]  depth;
  logic        halt;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

`ifdef CSAI_SEQ_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  // Reference model state
  int       m_addr = 0;
  int       m_stack[$];
  bit [1:0] m_err = 2'b00;
  bit       m_halt = 1'b0;

  csai_sequencer #(.AW(11), .DEPTH(4), .RESET_ADDR(11'h000)) dut (
    .CSAI_SEQ_CLOCK_50            (clk),
    .CSAI_SEQ_RESET_InHigh        (rst),
    .CSAI_SEQ_ACK                 (ack),
    .CSAI_SEQ_OP_InBus            (op),
    .CSAI_SEQ_COND                (cond),
    .CSAI_SEQ_BranchAddress_InBus (br),
    .CSAI_SEQ_ERRCLR              (errclr),
    .CSAI_SEQ_CSAI_OutBus         (csai),
    .CSAI_SEQ_DEPTH_OutBus        (depth),
    .CSAI_SEQ_HALT                (halt),
    .CSAI_SEQ_ERR_OutBus          (err)
  );

  always #5 clk = ~clk;

  function automatic int nxt(input int a);
    return (a + 1) % 2048;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_addr = 0;
      m_stack.delete();
      m_err = 2'b00;
      m_halt = 1'b0;
    end else if (m_halt) begin
      if (errclr) begin
        m_err = 2'b00;
        m_halt = 1'b0;
      end
    end else if (ack) begin
      case (op)
        3'd0: ;
        3'd2: m_addr = int'(br);
        3'd3: m_addr = cond ? int'(br) : nxt(m_addr);
        3'd4: begin
          if (!STACK_EN) m_addr = int'(br);
          else if (m_stack.size() < 4) begin
            m_stack.push_back(nxt(m_addr));
            m_addr = int'(br);
          end else begin
            m_err[1] = 1'b1;
            m_halt = 1'b1;
          end
        end
        3'd5: begin
          if (!STACK_EN) m_addr = nxt(m_addr);
          else if (m_stack.size() > 0) m_addr = m_stack.pop_back();
          else begin
            m_err[0] = 1'b1;
            m_halt = 1'b1;
          end
        end
        default: m_addr = nxt(m_addr);
      endcase
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (csai !== 11'(m_addr) || depth !== 3'(m_stack.size()) || halt !== m_halt || err !== m_err) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t: got addr=%03h depth=%0d halt=%0b err=%02b, expected addr=%03h depth=%0d halt=%0b err=%02b",
                 $time, csai, depth, halt, err, m_addr, m_stack.size(), m_halt, m_err);
      end
    end
  end

  task automatic step(input logic r, input logic a, input logic [2:0] o,
                      input logic c, input logic [10:0] b, input logic e);
    @(negedge clk);
    rst = r; ack = a; op = o; cond = c; br = b; errclr = e;
    @(posedge clk);
    model_update();
    #1;
    $display("txn t=%0t rst=%0b ack=%0b op=%0d cond=%0b br=%03h errclr=%0b -> addr=%03h depth=%0d halt=%0b err=%02b",
             $time, r, a, o, c, b, e, csai, depth, halt, err);
  endtask

  task automatic lit(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  initial begin
    // 1: reset dominates an active INC
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 3'd1, 0, 11'h0, 0);
      cmp_en = 1'b1;
      lit("reset_addr", int'(csai), 0);
      lit("reset_status", int'({depth, halt, err}), 0);
    end
    // 2: increment wrap and ACK=0 hold
    step(0, 1, 3'd2, 0, 11'h7FE, 0);
    step(0, 1, 3'd1, 0, 11'h0, 0);  lit("inc_7ff", int'(csai), 'h7FF);
    step(0, 1, 3'd1, 0, 11'h0, 0);  lit("inc_wrap", int'(csai), 'h000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'd2, 1, 11'h555, 0); lit("ack0_hold", int'(csai), 'h000);
    end
    // 3: conditional and unconditional jumps
    step(0, 1, 3'd2, 0, 11'h010, 0);
    step(0, 1, 3'd3, 0, 11'h100, 0);  lit("jcond_0", int'(csai), 'h011);
    step(0, 1, 3'd3, 1, 11'h100, 0);  lit("jcond_1", int'(csai), 'h100);
    step(0, 1, 3'd2, 0, 11'h2AA, 0);  lit("jmp", int'(csai), 'h2AA);
    step(0, 1, 3'd0, 1, 11'h111, 0);  lit("hold_op", int'(csai), 'h2AA);
    step(0, 1, 3'd7, 0, 11'h111, 0);  lit("reserved_inc", int'(csai), 'h2AB);
    // 4: nested call/return
    step(0, 1, 3'd2, 0, 11'h020, 0);
    step(0, 1, 3'd4, 0, 11'h300, 0);
`ifdef CSAI_SEQ_STACK_EN
    lit("call1", int'({csai, depth}), ('h300 << 3) | 1);
    step(0, 1, 3'd4, 0, 11'h400, 0);  lit("call2", int'({csai, depth}), ('h400 << 3) | 2);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("ret1", int'({csai, depth}), ('h301 << 3) | 1);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("ret2", int'({csai, depth}), ('h021 << 3) | 0);
    // 5: overflow, halt, clear, underflow
    step(0, 1, 3'd4, 0, 11'h100, 0);
    step(0, 1, 3'd4, 0, 11'h101, 0);
    step(0, 1, 3'd4, 0, 11'h102, 0);
    step(0, 1, 3'd4, 0, 11'h103, 0);  lit("call_full", int'({csai, depth}), ('h103 << 3) | 4);
    step(0, 1, 3'd4, 0, 11'h200, 0);  lit("overflow", int'({csai, halt, err}), ('h103 << 3) | 3'b110);
    step(0, 1, 3'd1, 0, 11'h0, 0);    lit("halt_inc_ignored", int'({csai, halt, err}), ('h103 << 3) | 3'b110);
    step(0, 1, 3'd1, 0, 11'h0, 1);    lit("errclr", int'({depth, halt, err}), (4 << 3) | 3'b000);
    lit("errclr_addr", int'(csai), 'h103);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("pop_a", int'(csai), 'h103);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("pop_b", int'(csai), 'h102);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("pop_c", int'(csai), 'h101);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("pop_d", int'({csai, depth}), ('h022 << 3) | 0);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("underflow", int'({csai, halt, err}), ('h022 << 3) | 3'b101);
    step(0, 0, 3'd0, 0, 11'h0, 0);    lit("sticky_err", int'(err), 1);
    step(0, 1, 3'd2, 0, 11'h0, 1);    lit("errclr2", int'({csai, halt, err}), ('h022 << 3) | 3'b000);
    step(0, 1, 3'd1, 0, 11'h0, 1);    lit("errclr_run", int'({csai, halt, err}), ('h023 << 3) | 3'b000);
    // Reset in the middle of a call chain empties the stack
    step(0, 1, 3'd4, 0, 11'h555, 0);
    step(0, 1, 3'd4, 0, 11'h666, 0);  lit("pre_reset", int'(depth), 2);
    step(1, 1, 3'd4, 0, 11'h777, 0);  lit("mid_reset", int'({csai, depth}), 0);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("ret_after_reset", int'({halt, err}), 3'b101);
    step(1, 0, 3'd0, 0, 11'h0, 0);
`else
    lit("call1_nostack", int'({csai, depth}), ('h300 << 3) | 0);
    step(0, 1, 3'd4, 0, 11'h400, 0);  lit("call2_nostack", int'({csai, depth}), ('h400 << 3) | 0);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("ret1_nostack", int'(csai), 'h401);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("ret2_nostack", int'(csai), 'h402);
    // 6: CALL as JMP, RET as INC, never any error
    step(0, 1, 3'd4, 0, 11'h123, 0);  lit("call_as_jmp", int'({csai, depth}), ('h123 << 3) | 0);
    step(0, 1, 3'd5, 0, 11'h0, 0);    lit("ret_as_inc", int'({csai, halt, err}), ('h124 << 3) | 0);
    for (int i = 0; i < 6; i++) step(0, 1, 3'd5, 0, 11'h0, 0);
    lit("no_underflow", int'({csai, halt, err}), ('h12A << 3) | 0);
    step(1, 1, 3'd4, 0, 11'h777, 0);  lit("mid_reset", int'(csai), 0);
`endif
    step(0, 1, 3'd1, 0, 11'h0, 0);    lit("post_reset_inc", int'(csai), 1);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
